// File: rtl/mon_reply_scheduler_if.sv
// Packet handshake between the reply scheduler
// and the 40-bit monitor-bus packet sender.
interface mon_reply_if;
  logic [39:0] out_data;
  logic        out_valid;
  logic        sender_ready;

  modport master (
    output out_data,
    output out_valid,
    input  sender_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output sender_ready
  );
endinterface

// File: rtl/mon_reply_scheduler.sv
// Fixed-priority reply arbiter for the NeXT monitor bus:
// power-on ack, audio sample requests and buffered kb/mouse events.
module mon_reply_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic                          mon_clk,
  input  logic                          rst_n,
  input  logic                          power_on_req,
  input  logic                          kb_valid,
  input  logic                          kb_is_mouse,
  input  logic [15:0]                   kb_data,
  input  logic                          audio_req_mode,
  input  logic                          audio_req_tick,
  output logic                          data_loss,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count,
  mon_reply_if.master                   bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [39:0]     data_q, data_d;
  logic            power_pend, audio_pend;
  logic [16:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [LW-1:0]   level;
  logic [16:0]     head;
  logic            empty, full;
  logic            push, pop, drop;
  logic            g_pwr, g_aud, g_kb;

  assign head  = mem[rd_ptr];
  assign empty = (level == '0);
  assign full  = (level == LW'(FIFO_DEPTH));
  assign pop   = g_kb;
  // A full FIFO still takes a write when the head leaves this cycle.
  assign push  = kb_valid & (~full | pop);
  assign drop  = kb_valid & full & ~pop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    g_pwr   = 1'b0;
    g_aud   = 1'b0;
    g_kb    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (power_pend) begin
          g_pwr   = 1'b1;
          data_d  = {8'hC0, 32'h0};
          state_d = ISSUE;
        end else if (audio_pend) begin
          g_aud   = 1'b1;
          data_d  = {8'hC7, 32'h0};
          state_d = ISSUE;
        end else if (!empty) begin
          g_kb    = 1'b1;
          data_d  = {head[16] ? 8'hC6 : 8'hC5,
                     16'h0, head[15:0]};
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.sender_ready) begin
          cnt_d   = CW'(GAP_CYCLES - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mon_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge mon_clk or negedge rst_n) begin
    if (!rst_n) begin
      power_pend <= 1'b0;
      audio_pend <= 1'b0;
    end else begin
      power_pend <= (power_pend & ~g_pwr) | power_on_req;
      audio_pend <= audio_req_mode &
                    ((audio_pend & ~g_aud) | audio_req_tick);
    end
  end

  always_ff @(posedge mon_clk) begin
    if (push) mem[wr_ptr] <= {kb_is_mouse, kb_data};
  end

  always_ff @(posedge mon_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      data_loss  <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level     <= level + LW'(push) - LW'(pop);
      data_loss <= drop;
      if (drop && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

  assign bus.out_valid = (state_q == ISSUE);
  assign bus.out_data  = data_q;
  assign fifo_level    = level;

endmodule

// File: tb/tb_mon_reply_scheduler.sv
// Scoreboard bench for mon_reply_scheduler: expected packets
// are queued at stimulus time and popped on each transfer.
module tb_mon_reply_scheduler;
  localparam int D = 4;
  localparam int G = 16;

  logic        mon_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        power_on_req, kb_valid, kb_is_mouse;
  logic [15:0] kb_data;
  logic        audio_req_mode, audio_req_tick;
  logic        data_loss;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_count;

  mon_reply_if bus ();

  mon_reply_scheduler #(
    .FIFO_DEPTH(D),
    .GAP_CYCLES(G)
  ) dut (
    .mon_clk        (mon_clk),
    .rst_n          (rst_n),
    .power_on_req   (power_on_req),
    .kb_valid       (kb_valid),
    .kb_is_mouse    (kb_is_mouse),
    .kb_data        (kb_data),
    .audio_req_mode (audio_req_mode),
    .audio_req_tick (audio_req_tick),
    .data_loss      (data_loss),
    .fifo_level     (fifo_level),
    .drop_count     (drop_count),
    .bus            (bus)
  );

  always #5 mon_clk = ~mon_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          xfer_n = 0;
  int          valid_cyc = 0;
  int          loss_n = 0;
  logic [39:0] sb[$];
  int          xfer_t[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge mon_clk);
    #1;
  endtask

  task automatic wait_drain(int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk("drain_left", 64'(sb.size()), 0);
  endtask

  task automatic wait_valid(int max);
    int n = 0;
    while (!bus.out_valid && n < max) begin
      step();
      n++;
    end
    chk("valid_seen", 64'(bus.out_valid), 1);
  endtask

  always @(posedge mon_clk) cyc++;

  always @(negedge mon_clk) begin
    if (rst_n) begin
      if (bus.out_valid) valid_cyc++;
      if (data_loss) loss_n++;
      if (bus.out_valid && bus.sender_ready) begin
        xfer_n++;
        xfer_t.push_back(cyc + 1);
        if (sb.size() == 0) chk("unexpected_pkt", 64'(sb.size()), 1);
        else chk("pkt", bus.out_data, sb.pop_front());
      end
    end
  end

  initial begin
    int n0;
    int bad;
    logic [39:0] d0;
    power_on_req = 0; kb_valid = 0; kb_is_mouse = 0; kb_data = 0;
    audio_req_mode = 0; audio_req_tick = 0;
    bus.sender_ready = 1;
    repeat (3) step();
    chk("rst_valid", 64'(bus.out_valid), 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_level", 64'(fifo_level), 0);
    chk("rst_drops", 64'(drop_count), 0);
    chk("rst_loss", 64'(data_loss), 0);
    rst_n = 1;
    step();

    // single keyboard event
    valid_cyc = 0;
    kb_valid = 1; kb_data = 16'h1234; kb_is_mouse = 0;
    sb.push_back(40'hC5_0000_1234);
    step();
    kb_valid = 0;
    chk("t1_level1", 64'(fifo_level), 1);
    step();
    chk("t1_level0", 64'(fifo_level), 0);
    chk("t1_valid", 64'(bus.out_valid), 1);
    repeat (3) step();
    chk("t1_valid_cycles", 64'(valid_cyc), 1);
    chk("t1_drain", 64'(sb.size()), 0);
    repeat (G + 4) step();

    // three simultaneous requesters
    xfer_t.delete();
    power_on_req = 1; audio_req_mode = 1; audio_req_tick = 1;
    kb_valid = 1; kb_is_mouse = 1; kb_data = 16'hABCD;
    sb.push_back(40'hC0_0000_0000);
    sb.push_back(40'hC7_0000_0000);
    sb.push_back(40'hC6_0000_ABCD);
    step();
    power_on_req = 0; audio_req_tick = 0; kb_valid = 0;
    wait_drain(100);
    step();
    chk("t2_xfers", 64'(xfer_t.size()), 3);
    if (xfer_t.size() == 3) begin
      chk("t2_gap1", 64'(xfer_t[1] - xfer_t[0]), G + 2);
      chk("t2_gap2", 64'(xfer_t[2] - xfer_t[1]), G + 2);
    end
    audio_req_mode = 0;
    repeat (G + 4) step();

    // stall with ready low
    bus.sender_ready = 0;
    kb_valid = 1; kb_is_mouse = 0; kb_data = 16'h5555;
    sb.push_back(40'hC5_0000_5555);
    step();
    kb_valid = 0;
    wait_valid(10);
    d0 = bus.out_data;
    bad = 0;
    repeat (50) begin
      step();
      if (!bus.out_valid || bus.out_data !== d0) bad++;
    end
    chk("t3_stable", 64'(bad), 0);
    chk("t3_data", d0, 40'hC5_0000_5555);
    n0 = xfer_n;
    bus.sender_ready = 1;
    repeat (5) step();
    chk("t3_one_xfer", 64'(xfer_n - n0), 1);
    repeat (G + 4) step();

    // overflow and saturation
    bus.sender_ready = 0;
    loss_n = 0;
    for (int i = 0; i < 6; i++) begin
      kb_valid = 1; kb_is_mouse = i[0]; kb_data = 16'h0100 + 16'(i);
      if (i < 5)
        sb.push_back({i[0] ? 8'hC6 : 8'hC5, 16'h0, 16'h0100 + 16'(i)});
      step();
    end
    kb_valid = 0;
    step();
    chk("t4_loss_once", 64'(loss_n), 1);
    chk("t4_drops1", 64'(drop_count), 1);
    chk("t4_level_full", 64'(fifo_level), D);
    for (int i = 0; i < 300; i++) begin
      kb_valid = 1; kb_data = 16'h2000 + 16'(i);
      step();
    end
    kb_valid = 0;
    step();
    chk("t4_drops_sat", 64'(drop_count), 255);
    chk("t4_loss_all", 64'(loss_n), 301);
    bus.sender_ready = 1;
    wait_drain(200);
    repeat (G + 4) step();
    chk("t4_level_empty", 64'(fifo_level), 0);

    // audio cancelled during gap, tick ignored with mode low
    kb_valid = 1; kb_is_mouse = 0; kb_data = 16'h7777;
    sb.push_back(40'hC5_0000_7777);
    step();
    kb_valid = 0;
    wait_drain(20);
    n0 = xfer_n;
    audio_req_mode = 1; audio_req_tick = 1;
    step();
    audio_req_tick = 0;
    step();
    audio_req_mode = 0;
    repeat (40) step();
    audio_req_tick = 1;
    step();
    audio_req_tick = 0;
    repeat (30) step();
    chk("t5_no_audio", 64'(xfer_n - n0), 0);

    // reset while a packet is in ISSUE
    bus.sender_ready = 0;
    kb_valid = 1; kb_data = 16'h8888;
    step();
    kb_data = 16'h9999;
    step();
    kb_valid = 0;
    wait_valid(10);
    rst_n = 0;
    #1;
    chk("t6_valid_rst", 64'(bus.out_valid), 0);
    chk("t6_level_rst", 64'(fifo_level), 0);
    chk("t6_data_rst", bus.out_data, 0);
    step();
    rst_n = 1;
    bus.sender_ready = 1;
    n0 = xfer_n;
    repeat (40) step();
    chk("t6_no_stale", 64'(xfer_n - n0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
